config_frame_loader: RTL and testbench



---
 rtl/config_frame_loader_pkg.sv | 20 ++
 rtl/config_frame_loader_if.sv | 27 ++
 rtl/config_frame_loader_assembler.sv | 34 +++
 rtl/config_frame_loader.sv | 159 +++++++++++++++
 tb/tb_config_frame_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/config_frame_loader_pkg.sv
// Shared constants and state encoding for the configuration frame loader.
package config_frame_pkg;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

  // Frame-address word layout; bits [15:0] are reserved.
  localparam int COL_MSB   = 31;
  localparam int COL_LSB   = 24;
  localparam int FRAME_MSB = 23;
  localparam int FRAME_LSB = 16;

  typedef enum logic [1:0] {
    SYNC_WAIT    = 2'd0,
    GET_ADDR     = 2'd1,
    GET_DATA     = 2'd2,
    GET_CHECKSUM = 2'd3
  } state_e;

endpackage

// File: rtl/config_frame_loader_if.sv
// Word-stream input and fabric configuration outputs of the frame loader.
interface config_frame_loader_if #(
  parameter int NUM_COLS           = 10,
  parameter int NUM_ROWS           = 16,
  parameter int MAX_FRAMES_PER_COL = 20
);
  logic                          word_write_strobe_i;
  logic [31:0]                   write_data_i;
  logic [32*NUM_ROWS-1:0]        frame_data_o;
  logic [NUM_COLS-1:0]           col_select_o;
  logic [MAX_FRAMES_PER_COL-1:0] frame_strobe_o;
  logic                          busy_o;
  logic                          error_o;
  logic [15:0]                   frame_count_o;

  // Word producer (byte packer / bench).
  modport master (
    output word_write_strobe_i, write_data_i,
    input  frame_data_o, col_select_o, frame_strobe_o, busy_o, error_o, frame_count_o
  );

  // Frame loader.
  modport slave (
    input  word_write_strobe_i, write_data_i,
    output frame_data_o, col_select_o, frame_strobe_o, busy_o, error_o, frame_count_o
  );
endinterface

// File: rtl/config_frame_loader_assembler.sv
// Row counter and assembly register: collects NUM_ROWS 32-bit slices of one frame.
module config_frame_assembler #(
  parameter int NUM_ROWS = 16,
  parameter int RW       = $clog2(NUM_ROWS)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clear_i,
  input  logic                     write_i,
  input  logic [31:0]              data_i,
  output logic [NUM_ROWS-1:0][31:0] asm_o,
  output logic                     last_o
);

  logic [RW-1:0]              row_cnt_q;
  logic [NUM_ROWS-1:0][31:0]  asm_q;

  assign last_o = (row_cnt_q == RW'(NUM_ROWS - 1));
  assign asm_o  = asm_q;

  // Write the current row slice and advance; the counter restarts after the last row.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      row_cnt_q <= '0;
      asm_q     <= '0;
    end else if (clear_i) begin
      row_cnt_q <= '0;
    end else if (write_i) begin
      asm_q[row_cnt_q] <= data_i;
      row_cnt_q        <= last_o ? '0 : row_cnt_q + RW'(1);
    end
  end

endmodule

// File: rtl/config_frame_loader.sv
// Configuration frame loader: sync detection, frame-address decode and frame
// assembly feeding the fabric configuration chain.
// Optional build macro CONFIG_FRAME_CHECKSUM_EN adds an XOR checksum over all
// data words since SYNC, checked against the word following DESYNC.
module config_frame_loader
  import config_frame_pkg::*;
#(
  parameter int NUM_COLS           = 10,
  parameter int NUM_ROWS           = 16,
  parameter int MAX_FRAMES_PER_COL = 20
) (
  input logic                  clk_i,
  input logic                  reset_n_i,
  config_frame_loader_if.slave bus
);

  state_e                        state_q, state_d;
  logic [7:0]                    col_q, col_d;
  logic [7:0]                    frame_q, frame_d;
  logic [NUM_COLS-1:0]           col_sel_q, col_sel_d;
  logic [MAX_FRAMES_PER_COL-1:0] strobe_q, strobe_d;
  logic [32*NUM_ROWS-1:0]        frame_data_q, frame_data_d;
  logic                          error_q, error_d;
  logic [15:0]                   count_q, count_d;
`ifdef CONFIG_FRAME_CHECKSUM_EN
  logic [31:0]                   csum_q, csum_d;
`endif

  logic                      wr;
  logic [31:0]               wd;
  logic [7:0]                addr_col, addr_frame;
  logic                      asm_clear, asm_write, asm_last;
  logic [NUM_ROWS-1:0][31:0] asm_rows;

  assign wr         = bus.word_write_strobe_i;
  assign wd         = bus.write_data_i;
  assign addr_col   = wd[COL_MSB:COL_LSB];
  assign addr_frame = wd[FRAME_MSB:FRAME_LSB];

  config_frame_assembler #(.NUM_ROWS(NUM_ROWS)) u_asm (
    .clk_i   (clk_i),
    .rst_n_i (reset_n_i),
    .clear_i (asm_clear),
    .write_i (asm_write),
    .data_i  (wd),
    .asm_o   (asm_rows),
    .last_o  (asm_last)
  );

  // Next-state and output decode; only strobed words change anything, and the
  // column/frame pulses default to zero so they last exactly one cycle.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    frame_d      = frame_q;
    col_sel_d    = '0;
    strobe_d     = '0;
    frame_data_d = frame_data_q;
    error_d      = error_q;
    count_d      = count_q;
    asm_clear    = 1'b0;
    asm_write    = 1'b0;
`ifdef CONFIG_FRAME_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    if (wr) begin
      case (state_q)
        SYNC_WAIT: begin
          if (wd == SYNC_WORD) begin
            state_d = GET_ADDR;
            error_d = 1'b0;
            count_d = '0;
`ifdef CONFIG_FRAME_CHECKSUM_EN
            csum_d  = '0;
`endif
          end
        end
        GET_ADDR: begin
          if (wd == DESYNC_WORD) begin
`ifdef CONFIG_FRAME_CHECKSUM_EN
            state_d = GET_CHECKSUM;
`else
            state_d = SYNC_WAIT;
`endif
          end else if (int'(addr_col) >= NUM_COLS ||
                       int'(addr_frame) >= MAX_FRAMES_PER_COL) begin
            error_d = 1'b1;
            state_d = SYNC_WAIT;
          end else begin
            col_d     = addr_col;
            frame_d   = addr_frame;
            asm_clear = 1'b1;
            state_d   = GET_DATA;
          end
        end
        GET_DATA: begin
          asm_write = 1'b1;
`ifdef CONFIG_FRAME_CHECKSUM_EN
          csum_d    = csum_q ^ wd;
`endif
          if (asm_last) begin
            // The last row bypasses the assembly register so the frame is complete now.
            frame_data_d = {wd, asm_rows[NUM_ROWS-2:0]};
            col_sel_d    = NUM_COLS'(1) << col_q;
            strobe_d     = MAX_FRAMES_PER_COL'(1) << frame_q;
            count_d      = (count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
            state_d      = GET_ADDR;
          end
        end
        GET_CHECKSUM: begin
`ifdef CONFIG_FRAME_CHECKSUM_EN
          if (wd != csum_q) error_d = 1'b1;
`endif
          state_d = SYNC_WAIT;
        end
        default: state_d = SYNC_WAIT;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= SYNC_WAIT;
      col_q        <= '0;
      frame_q      <= '0;
      col_sel_q    <= '0;
      strobe_q     <= '0;
      frame_data_q <= '0;
      error_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      frame_q      <= frame_d;
      col_sel_q    <= col_sel_d;
      strobe_q     <= strobe_d;
      frame_data_q <= frame_data_d;
      error_q      <= error_d;
      count_q      <= count_d;
    end
  end

`ifdef CONFIG_FRAME_CHECKSUM_EN
  // Running XOR of accepted data words since the last SYNC.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) csum_q <= '0;
    else            csum_q <= csum_d;
  end
`endif

  assign bus.frame_data_o   = frame_data_q;
  assign bus.col_select_o   = col_sel_q;
  assign bus.frame_strobe_o = strobe_q;
  assign bus.busy_o         = (state_q != SYNC_WAIT);
  assign bus.error_o        = error_q;
  assign bus.frame_count_o  = count_q;

endmodule

// File: tb/tb_config_frame_loader.sv
// Randomized scoreboard bench for config_frame_loader.
module tb_config_frame_loader;
  localparam int NC = 10;
  localparam int NR = 16;
  localparam int MF = 20;
`ifdef CONFIG_FRAME_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  config_frame_loader_if #(.NUM_COLS(NC), .NUM_ROWS(NR), .MAX_FRAMES_PER_COL(MF)) bus ();

  config_frame_loader #(.NUM_COLS(NC), .NUM_ROWS(NR), .MAX_FRAMES_PER_COL(MF)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  typedef struct {
    longint              due;
    logic [NC-1:0]       col;
    logic [MF-1:0]       strb;
    logic [32*NR-1:0]    data;
    logic [15:0]         cnt;
  } exp_t;

  exp_t   expq[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: 0 = waiting for sync, 1 = expecting address,
  // 2 = collecting rows, 3 = expecting checksum word.
  int               mst = 0;
  int               cur_c, cur_f;
  logic [31:0]      rows[$];
  logic [31:0]      acc = '0;
  logic             exp_err = 1'b0;
  logic [15:0]      exp_cnt = '0;
  logic [32*NR-1:0] last_data = '0;

  function automatic void model_reset();
    mst = 0; acc = '0; exp_err = 1'b0; exp_cnt = '0; last_data = '0; rows.delete();
  endfunction

  function automatic void model(input logic [31:0] w);
    exp_t e;
    int c, f;
    case (mst)
      0: if (w == SYNC) begin mst = 1; exp_err = 1'b0; exp_cnt = '0; acc = '0; end
      1: begin
        c = int'(w[31:24]);
        f = int'(w[23:16]);
        if (w == DESYNC) mst = CSUM_EN ? 3 : 0;
        else if (c >= NC || f >= MF) begin exp_err = 1'b1; mst = 0; end
        else begin cur_c = c; cur_f = f; rows.delete(); mst = 2; end
      end
      2: begin
        rows.push_back(w);
        acc ^= w;
        if (rows.size() == NR) begin
          e.due = cyc + 1;
          e.col = '0; e.col[cur_c] = 1'b1;
          e.strb = '0; e.strb[cur_f] = 1'b1;
          for (int k = 0; k < NR; k++) e.data[32*k +: 32] = rows[k];
          if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
          e.cnt = exp_cnt;
          last_data = e.data;
          expq.push_back(e);
          mst = 1;
        end
      end
      default: begin
        if (w != acc) exp_err = 1'b1;
        mst = 0;
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic send(input logic [31:0] w);
    @(posedge clk); #1;
    bus.word_write_strobe_i = 1'b1;
    bus.write_data_i        = w;
    model(w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.word_write_strobe_i = 1'b0;
      bus.write_data_i        = $urandom;
    end
  endtask

  task automatic chk_flags(input string tag);
    idle(1);
    @(negedge clk);
    chk({tag, "_busy"},  64'(bus.busy_o), 64'(mst != 0));
    chk({tag, "_error"}, 64'(bus.error_o), 64'(exp_err));
    chk({tag, "_count"}, 64'(bus.frame_count_o), 64'(exp_cnt));
    chk({tag, "_hold"},  64'(bus.frame_data_o != last_data), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},  64'(bus.frame_data_o != '0), 64'd0);
    chk({tag, "_col"},   64'(bus.col_select_o), 64'd0);
    chk({tag, "_strb"},  64'(bus.frame_strobe_o), 64'd0);
    chk({tag, "_busy"},  64'(bus.busy_o), 64'd0);
    chk({tag, "_error"}, 64'(bus.error_o), 64'd0);
    chk({tag, "_count"}, 64'(bus.frame_count_o), 64'd0);
  endtask

  task automatic send_frame(input int c, input int f, input logic [31:0] base, input bit rnd);
    send({8'(c), 8'(f), 16'($urandom)});
    for (int k = 0; k < NR; k++) send(rnd ? 32'($urandom) : base + 32'(k));
  endtask

  // Monitor: pops the scoreboard whenever a frame pulse appears.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0 && expq[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL missed_frame: no strobe, expected strb %0h at cycle %0d", expq[0].strb, expq[0].due);
      void'(expq.pop_front());
    end
    if (bus.frame_strobe_o != '0) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got strb %0h col %0h, expected none", bus.frame_strobe_o, bus.col_select_o);
      end else begin
        e = expq.pop_front();
        if (bus.col_select_o !== e.col || bus.frame_strobe_o !== e.strb ||
            bus.frame_count_o !== e.cnt || e.due != cyc || bus.frame_data_o !== e.data) begin
          errors++;
          $display("FAIL frame: got col %0h strb %0h cnt %0d cyc %0d data %0h expected col %0h strb %0h cnt %0d cyc %0d data %0h",
                   bus.col_select_o, bus.frame_strobe_o, bus.frame_count_o, cyc, bus.frame_data_o,
                   e.col, e.strb, e.cnt, e.due, e.data);
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    bus.word_write_strobe_i = 1'b0;
    bus.write_data_i        = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    #1 rst_n = 1'b1;

    // Words before SYNC are ignored.
    send(32'hDEAD_BEEF);
    send(DESYNC);
    chk_flags("presync");
    send(SYNC);
    chk_flags("sync");

    // Basic frame: column 3, frame 5.
    send_frame(3, 5, 32'h1000_0000, 1'b0);
    chk_flags("frame1");

    // Out-of-range address fields.
    send(32'h0A00_0000);
    chk_flags("badcol");
    send(SYNC);
    chk_flags("resync1");
    send(32'h0014_0000);
    chk_flags("badframe");
    send(SYNC);

    // Back-to-back frames: second address arrives in the strobe cycle.
    send_frame(9, 19, 32'h2000_0000, 1'b0);
    send_frame(0, 0, 32'h3000_0000, 1'b0);
    chk_flags("b2b");

    // Reset mid-frame, then resend the whole sequence.
    send({8'd2, 8'd7, 16'h0});
    for (int k = 0; k < 7; k++) send(32'h4000_0000 + 32'(k));
    @(posedge clk); #1;
    bus.word_write_strobe_i = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk_zero("midrst");
    #1 rst_n = 1'b1;
    send(SYNC);
    send_frame(2, 7, 32'h4000_0000, 1'b0);
    chk_flags("afterrst");

`ifdef CONFIG_FRAME_CHECKSUM_EN
    send(DESYNC);
    send(acc);
    chk_flags("csum_ok");
    chk("csum_ok_err", 64'(bus.error_o), 64'd0);
    send(SYNC);
    send_frame(5, 11, 32'h5000_0000, 1'b1);
    send(DESYNC);
    send(acc ^ 32'd1);
    chk_flags("csum_bad");
    chk("csum_bad_err", 64'(bus.error_o), 64'd1);
`endif

    // Randomized word stream with gaps.
    for (int i = 0; i < 1500; i++) begin
      case (mst)
        0: w = ($urandom_range(0, 9) < 8) ? SYNC : 32'($urandom);
        1: begin
          case ($urandom_range(0, 9))
            0: w = DESYNC;
            1: w = {8'($urandom_range(NC, 255)), 8'($urandom_range(0, MF - 1)), 16'($urandom)};
            2: w = {8'($urandom_range(0, NC - 1)), 8'($urandom_range(MF, 255)), 16'($urandom)};
            default: w = {8'($urandom_range(0, NC - 1)), 8'($urandom_range(0, MF - 1)), 16'($urandom)};
          endcase
        end
        2: w = ($urandom_range(0, 19) == 0) ? (($urandom_range(0, 1) == 1) ? SYNC : DESYNC) : 32'($urandom);
        default: w = ($urandom_range(0, 1) == 1) ? acc : 32'($urandom);
      endcase
      send(w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      if (i % 100 == 99) chk_flags("rand");
    end

    idle(3);
    @(negedge clk);
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
